// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative restoring divide/remainder (DIV, DIVU, REM, REMU) with pipeline stall.
// Optional early-out for |dividend| < |divisor| enabled by defining DIV_EARLY_OUT_EN.
`default_nettype none

module div_rem_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr_a,
  input  logic [WIDTH-1:0] opr_b,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   dsr_mag;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic             early;
  logic             accept;
  logic [WIDTH:0]   shift;
  logic             ge;

  // Request classification on the raw inputs, used only in the accepting cycle.
  assign sgn      = ~op[0];
  assign a_neg    = sgn & opr_a[WIDTH-1];
  assign b_neg    = sgn & opr_b[WIDTH-1];
  assign a_abs    = a_neg ? -opr_a : opr_a;
  assign b_abs    = b_neg ? -opr_b : opr_b;
  assign div_zero = (opr_b == '0);
  assign ovf      = sgn & (opr_a == MIN_NEG) & (opr_b == '1);
  assign special  = div_zero | ovf;
  assign accept   = (state == S_IDLE) & valid_in;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? opr_a : '1;
    else if (ovf)
      special_res = op[1] ? '0 : MIN_NEG;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early = ~special & (a_abs < b_abs);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shift = {rem, dvd[WIDTH-1]};
  assign ge    = (shift >= dsr_mag);

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (valid_in) begin
          if (special)
            state_nxt = S_DONE;
          else if (early)
            state_nxt = S_FIX;
          else
            state_nxt = S_CALC;
        end
      end
      S_CALC:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    valid_out = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dsr_mag <= '0;
      dvd     <= '0;
      rem     <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      if (accept) begin
        is_rem  <= op[1];
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        dsr_mag <= {1'b0, b_abs};
        cnt     <= CNT_LAST;
        dvd     <= early ? '0 : a_abs;
        rem     <= early ? a_abs : '0;
        if (special)
          result <= special_res;
      end else if (state == S_CALC) begin
        rem <= ge ? WIDTH'(shift - dsr_mag) : shift[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], ge};
        cnt <= cnt - 1'b1;
      end else if (state == S_FIX) begin
        if (is_rem)
          result <= neg_r ? -rem : rem;
        else
          result <= neg_q ? -dvd : dvd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_rem_unit.sv
// tb_div_rem_unit: directed scoreboard bench for div_rem_unit (WIDTH=32), results and latency.
`default_nettype none

module tb_div_rem_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif
  localparam int FULL_LAT = 34;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  op;
  logic [31:0] opr_a;
  logic [31:0] opr_b;
  logic        busy;
  logic        valid_out;
  logic [31:0] result;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_v   = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  exp_t mon_e;
  int   mon_acc;

  div_rem_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .op        (op),
    .opr_a     (opr_a),
    .opr_b     (opr_b),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid_out pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0 && acc_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_valid_out observed=1 expected=0 at cycle %0d", cyc);
      end
      if (exp_q.size() > 0 && acc_q.size() > 0) begin
        mon_e   = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        chk({mon_e.name, "_result"}, result, mon_e.res);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_acc + 1), 32'(mon_e.lat));
        last_v = cyc;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    wait_idle();
    e.name = name; e.res = res; e.lat = lat;
    op = o; opr_a = a; opr_b = b; valid_in = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 acc_q.push_back(cyc);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input int lat);
    issue(name, o, a, b, res, lat);
    drain();
  endtask

  initial begin
    exp_t eb;
    int   accb;
    int   n;

    // Reset with a competing request: reset must win.
    rst = 1'b1; valid_in = 1'b1; op = 2'b01; opr_a = 32'd100; opr_b = 32'd7;
    repeat (2) @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_result", result, 32'd0);
    repeat (40) @(negedge clk);

    run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, FULL_LAT);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, FULL_LAT);
    run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
    run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);
    run("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, FULL_LAT);
    run("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT);
    run("div_m7_m2",  2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, FULL_LAT);

    run("div_by0",  2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0",  2'b10, 32'h1234, 32'd0, 32'h0000_1234, 1);
    run("divu_by0", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h0000_1234, 1);
    run("div_ovf",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_LAT);
    run("remu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT);

    run("remu_3_10", 2'b11, 32'd3, 32'd10, 32'd3, EARLY_LAT);
    run("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EARLY_LAT);
    run("div_m3_10", 2'b00, 32'hFFFF_FFFD, 32'd10, 32'd0, EARLY_LAT);

    // Mid-CALC pulse is ignored; a held request is taken in the IDLE cycle after DONE.
    issue("hs_divu_1000_3", 2'b01, 32'd1000, 32'd3, 32'd333, FULL_LAT);
    repeat (5) @(negedge clk);
    op = 2'b00; opr_a = 32'd50; opr_b = 32'd5; valid_in = 1'b1;
    @(negedge clk);
    op = 2'b11; opr_a = 32'd1000; opr_b = 32'd7;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hs_hold_timeout", 32'(n < 200), 32'd1);
    eb.name = "hs_remu_1000_7"; eb.res = 32'd6; eb.lat = FULL_LAT;
    exp_q.push_back(eb);
    @(posedge clk);
    #1 accb = cyc;
    acc_q.push_back(accb);
    chk("b2b_accept_cycle", 32'(accb), 32'(last_v + 2));
    @(negedge clk);
    valid_in = 1'b0;
    drain();

    // Reset in CALC cycle 10 abandons the request.
    issue("abandoned", 2'b01, 32'h0000_FFFF, 32'd3, 32'h0000_5555, FULL_LAT);
    repeat (9) @(negedge clk);
    exp_q.delete();
    acc_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_valid_out", {31'd0, valid_out}, 32'd0);
    repeat (40) @(negedge clk);

    run("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, FULL_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_rem_unit.md
Name: div_rem_unit

Overview:
- Iterative multi-cycle integer divide/remainder unit for the execute stage of the 3-phase RISC-V pipeline.
- Sits beside the combinational ALU and takes the same opr_a/opr_b operands.
- Handles the MOD opcode slot plus RV32M DIV/DIVU/REM/REMU.
- While busy it drives a stall so the fetch/decode stages hold until the result is ready for writeback.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  request strobe; sampled only while busy=0.
- op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder, the MOD op), 11 REMU.
- opr_a  input  WIDTH  dividend.
- opr_b  input  WIDTH  divisor.
- busy  output  1  high from the cycle after acceptance until the result is presented; pipeline stall request.
- valid_out  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  quotient or remainder; holds its value until the next accepted request.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: busy=0, valid_out=0, result=0. State goes to IDLE; counter and working registers are cleared.
- Reset mid-operation: the result is abandoned and the next cycle is IDLE. No valid_out is produced for the abandoned request.
- States:
  - IDLE: if valid_in=1, latch op and operands, then classify:
    - divisor==0 or signed overflow → DONE.
    - otherwise → CALC.
  - CALC: restoring shift-subtract on magnitudes, one quotient bit per cycle, MSB first. Runs exactly WIDTH cycles (counter WIDTH-1 down to 0), then → FIX.
  - FIX: one cycle of sign correction, then → DONE.
    - Signed quotient is negated when the operand signs differ.
    - Signed remainder takes the sign of the dividend.
    - Unsigned ops use the raw magnitudes.
  - DONE: valid_out=1 for exactly this cycle with result driven, then → IDLE.
- Magnitudes: signed ops take two's-complement absolute values, held in WIDTH+1-bit working registers so -2^(WIDTH-1) is representable. Unsigned ops zero-extend.
- Latency:
  - Normal path: valid_out is high in the cycle after clock edge N+WIDTH+1, where N is the accepting edge (WIDTH+2 cycles; 34 for WIDTH=32).
  - Special cases: valid_out is high in the cycle directly after the accepting edge.
- busy = (state != IDLE) and is registered. It is high in CALC, FIX and DONE, and drops in the cycle after DONE.
- valid_in while busy=1 is ignored and not queued. The requester holds the request until busy=0.
- A new request may be accepted in the IDLE cycle immediately after DONE (back-to-back).
- Division by zero (all ops): quotient = all ones; remainder = opr_a unmodified.
- Signed overflow (DIV/REM, opr_a = -2^(WIDTH-1), opr_b = -1): quotient = -2^(WIDTH-1); remainder = 0.
- rst and valid_in in the same cycle: rst wins, and the request is not accepted.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the dividend magnitude is less than the divisor magnitude (divisor nonzero, not overflow):
  - skip CALC and go to FIX with quotient=0 and remainder=dividend magnitude;
  - FIX applies the normal sign rules;
  - valid_out follows the accepting edge by 2 cycles.
- Not defined: every non-special request takes the full WIDTH+2 cycles.
- Results are identical either way; only latency differs.

Test Plan:
- Reset: assert rst with valid_in=1 for 2 cycles, then release → busy=0, valid_out=0, result=0, and no pulse follows.
- DIVU and REMU:
  - opr_a=100, opr_b=7, op=01 → result=14, valid_out pulse exactly 34 cycles after acceptance.
  - Repeat with op=11 → result=2.
- Signed DIV and REM:
  - opr_a=-7 (0xFFFFFFF9), opr_b=2, op=00 → 0xFFFFFFFD (-3).
  - Same operands, op=10 → 0xFFFFFFFF (-1).
  - opr_a=7, opr_b=-2, op=10 → 1.
- Special cases:
  - opr_b=0, opr_a=0x1234, op=00 → 0xFFFFFFFF.
  - Same operands, op=10 → 0x1234; valid_out one cycle after acceptance.
  - opr_a=0x80000000, opr_b=0xFFFFFFFF, op=00 → 0x80000000; with op=10 → 0.
- Handshake:
  - Pulse valid_in again mid-CALC with different operands → ignored; first result unchanged.
  - Request in the cycle after DONE → accepted; second result correct.
  - Assert rst in CALC cycle 10 → no valid_out, busy=0 next cycle.
- DIV_EARLY_OUT_EN: opr_a=3, opr_b=10, op=11 → result=3.
  - Macro defined: valid_out 2 cycles after acceptance.
  - Macro undefined: 34 cycles after acceptance.
